// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
//   FWD_*      operand source select codes (regfile / M result / W result)
//   TUSE_NONE  tuse value meaning "source not read"
//   sb_entry_t one scoreboard slot: destination, cycles-to-ready, movz flag
//   tnew_dec   saturating decrement applied as an entry advances a stage
package hazard_pkg;

  localparam int SB_RW = 5;
  localparam int SB_TW = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [SB_RW-1:0] dst;
    logic [SB_TW-1:0] tnew;
    logic             movz;
  } sb_entry_t;

  function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: three-slot (E, M, W) record of in-flight writers.
// Ports:
//   clk, reset   pipeline clock; synchronous active-high clear
//   stall        load a bubble into E instead of the D instruction
//   e_rt_zero    rt of the E instruction is zero (resolves movz on exit)
//   d_in         D-stage candidate entry
//   e, m, w      current slot contents
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      stall,
  input  logic      e_rt_zero,
  input  sb_entry_t d_in,
  output sb_entry_t e,
  output sb_entry_t m,
  output sb_entry_t w
);

  // The countdown keeps ticking as an entry moves E->M->W so that a load
  // (tnew 2) reaches 0 exactly when it sits in W.
  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      m <= '0;
      w <= '0;
    end else begin
      w.dst  <= m.dst;
      w.tnew <= tnew_dec(m.tnew);
      w.movz <= 1'b0;
      // movz with nonzero rt never writes: its destination becomes $0.
      m.dst  <= (e.movz && !e_rt_zero) ? '0 : e.dst;
      m.tnew <= tnew_dec(e.tnew);
      m.movz <= 1'b0;
      e      <= stall ? '0 : d_in;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, forwarding and movz destination control for the
// five-stage pipeline.
// Ports:
//   clk, reset             pipeline clock; synchronous active-high clear
//   d_rs/d_rt, d_tuse_*    D-stage sources and when they are consumed
//   d_dst, d_tnew, d_movz  D-stage writer description
//   e_rt_zero              forwarded rt value in E is zero
//   e_rs, e_rt, m_rt       sources held in ID/EX and EX/MEM
//   stall                  freeze PC and IF/ID, bubble into ID/EX
//   e_dst_sel              1 = keep E destination, 0 = force $0
//   fwd_rs_d/fwd_rt_d      D operand source (FWD_RF/FWD_M/FWD_W)
//   fwd_rs_e/fwd_rt_e      E operand source
//   fwd_rt_m               M store data from W result
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [RW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_movz,
  input  logic          e_rt_zero,
  input  logic [RW-1:0] e_rs,
  input  logic [RW-1:0] e_rt,
  input  logic [RW-1:0] m_rt,
  output logic          stall,
  output logic          e_dst_sel,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          fwd_rt_m
);

  localparam int NSRC = 2;

  sb_entry_t sb_e, sb_m, sb_w, d_ent;
  logic      stall_raw;

  assign d_ent = '{dst: d_dst, tnew: d_tnew, movz: d_movz};

  hazard_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall_raw),
    .e_rt_zero (e_rt_zero),
    .d_in      (d_ent),
    .e         (sb_e),
    .m         (sb_m),
    .w         (sb_w)
  );

  // A source waits while a producer in E or M still needs more cycles than
  // the consumer can wait. E uses the unresolved movz destination on purpose:
  // the cancel is not known until the instruction is in E.
  function automatic logic src_haz(input logic [RW-1:0] r, input logic [TW-1:0] tuse,
                                   input sb_entry_t e, input sb_entry_t m);
    if (tuse == TUSE_NONE || r == '0) return 1'b0;
    return (e.dst == r && e.tnew > tuse) || (m.dst == r && m.tnew > tuse);
  endfunction

  function automatic logic ready_hit(input logic [RW-1:0] r, input sb_entry_t s);
    return (r != '0) && (s.dst == r) && (s.tnew == '0);
  endfunction

  // M is younger than W, so its value wins on a double match.
  function automatic logic [1:0] fwd_src(input logic [RW-1:0] r,
                                         input sb_entry_t m, input sb_entry_t w);
    if (ready_hit(r, m)) return FWD_M;
    if (ready_hit(r, w)) return FWD_W;
    return FWD_RF;
  endfunction

  logic [NSRC-1:0][RW-1:0] d_src, e_src;
  logic [NSRC-1:0][TW-1:0] d_tuse;
  logic [NSRC-1:0][1:0]    fwd_d, fwd_e;
  logic [NSRC-1:0]         haz;

  assign d_src  = {d_rt, d_rs};
  assign e_src  = {e_rt, e_rs};
  assign d_tuse = {d_tuse_rt, d_tuse_rs};

  // Outputs are forced idle during reset so a stale scoreboard never leaks
  // into the cycle in which it is being cleared.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign haz[i]   = src_haz(d_src[i], d_tuse[i], sb_e, sb_m);
    assign fwd_d[i] = reset ? FWD_RF : fwd_src(d_src[i], sb_m, sb_w);
    assign fwd_e[i] = reset ? FWD_RF : fwd_src(e_src[i], sb_m, sb_w);
  end

  assign stall_raw = !reset && (|haz);
  assign stall     = stall_raw;
  assign e_dst_sel = reset || !sb_e.movz || e_rt_zero;
  assign fwd_rs_d  = fwd_d[0];
  assign fwd_rt_d  = fwd_d[1];
  assign fwd_rs_e  = fwd_e[0];
  assign fwd_rt_e  = fwd_e[1];
  assign fwd_rt_m  = !reset && ready_hit(m_rt, sb_w);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst, e_rs, e_rt, m_rt;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_movz, e_rt_zero;
  logic       stall, e_dst_sel, fwd_rt_m;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RW(5), .TW(2)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_movz(d_movz), .e_rt_zero(e_rt_zero),
    .e_rs(e_rs), .e_rt(e_rt), .m_rt(m_rt),
    .stall(stall), .e_dst_sel(e_dst_sel),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] urs,
                       input logic [4:0] rt, input logic [1:0] urt,
                       input logic [4:0] dst, input logic [1:0] tn, input logic mz);
    d_rs = rs; d_tuse_rs = urs; d_rt = rt; d_tuse_rt = urt;
    d_dst = dst; d_tnew = tn; d_movz = mz;
  endtask

  task automatic clear_in();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    e_rs = '0; e_rt = '0; m_rt = '0; e_rt_zero = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall); end
    n_cmp++; if (e_dst_sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel got %0d want 1", e_dst_sel); end
    n_cmp++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0) begin
      n_bad++; $display("FAIL reset_fwd got %0h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}); end
    // load $8 in E, branch reading $8 in D: would stall
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
    cyc();
    set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL prereset_stall got %0d want 1", stall); end
    reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midreset_stall got %0d want 0", stall); end
    cyc(); cyc();
    reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL postreset_stall got %0d want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd0) begin n_bad++; $display("FAIL postreset_fwd_d got %0d want 0", fwd_rs_d); end
    cyc(); cyc();
    e_rs = 5'd8;
    #1;
    n_cmp++; if (fwd_rs_e !== 2'd0) begin n_bad++; $display("FAIL postreset_stale_fwd got %0d want 0", fwd_rs_e); end
    // movz cancel in E is overridden while reset is high
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1);
    cyc();
    clear_in();
    #1;
    n_cmp++; if (e_dst_sel !== 1'b0) begin n_bad++; $display("FAIL movz_sel_prereset got %0d want 0", e_dst_sel); end
    reset = 1'b1;
    #1;
    n_cmp++; if (e_dst_sel !== 1'b1) begin n_bad++; $display("FAIL movz_sel_reset got %0d want 1", e_dst_sel); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
    cyc();
    set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 2'd1, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall1 got %0d want 1", stall); end
    cyc();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall2 got %0d want 0", stall); end
    cyc();
    clear_in();
    e_rs = 5'd8; e_rt = 5'd9;
    #1;
    n_cmp++; if (fwd_rs_e !== 2'd2) begin n_bad++; $display("FAIL lu_fwd_rs_e got %0d want 2", fwd_rs_e); end
    n_cmp++; if (fwd_rt_e !== 2'd0) begin n_bad++; $display("FAIL lu_fwd_rt_e got %0d want 0", fwd_rt_e); end
    // branch on a load: two stall cycles, then W
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0);
    cyc();
    set_d(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lbr_stall1 got %0d want 1", stall); end
    cyc(); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lbr_stall2 got %0d want 1", stall); end
    cyc(); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lbr_stall3 got %0d want 0", stall); end
    n_cmp++; if (fwd_rt_d !== 2'd2) begin n_bad++; $display("FAIL lbr_fwd_rt_d got %0d want 2", fwd_rt_d); end
  endtask

  task automatic test_branch_alu();
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0);
    cyc();
    set_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL br_stall1 got %0d want 1", stall); end
    cyc(); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL br_stall2 got %0d want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd1) begin n_bad++; $display("FAIL br_fwd_rs_d got %0d want 1", fwd_rs_d); end
  endtask

  task automatic test_movz(input logic rtz);
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 1'b1);
    cyc();
    set_d(5'd10, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    e_rt_zero = rtz;
    #1;
    n_cmp++; if (e_dst_sel !== rtz) begin n_bad++; $display("FAIL movz_sel got %0d want %0d", e_dst_sel, rtz); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL movz_stall got %0d want 0", stall); end
    cyc();
    clear_in();
    d_rs = 5'd10; d_tuse_rs = 2'd1; e_rs = 5'd10;
    #1;
    n_cmp++; if (fwd_rs_e !== (rtz ? 2'd1 : 2'd0)) begin n_bad++;
      $display("FAIL movz_fwd_e got %0d want %0d", fwd_rs_e, rtz ? 1 : 0); end
    n_cmp++; if (fwd_rs_d !== (rtz ? 2'd1 : 2'd0)) begin n_bad++;
      $display("FAIL movz_fwd_d got %0d want %0d", fwd_rs_d, rtz ? 1 : 0); end
  endtask

  task automatic test_double_zero();
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0);
    cyc(); cyc();
    clear_in();
    cyc();
    set_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    e_rs = 5'd5; m_rt = 5'd5;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL dbl_stall got %0d want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd1) begin n_bad++; $display("FAIL dbl_fwd_d got %0d want 1", fwd_rs_d); end
    n_cmp++; if (fwd_rs_e !== 2'd1) begin n_bad++; $display("FAIL dbl_fwd_e got %0d want 1", fwd_rs_e); end
    n_cmp++; if (fwd_rt_m !== 1'b1) begin n_bad++; $display("FAIL dbl_fwd_m got %0d want 1", fwd_rt_m); end
    // writer of $0 (load latency) followed by readers of $0
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0);
    cyc();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall got %0d want 0", stall); end
    cyc(); cyc();
    #1;
    n_cmp++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0) begin n_bad++;
      $display("FAIL zero_fwd got %0h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}); end
  endtask

  // Reference model: each in-flight instruction carries its age in stages
  // past D (0 = E, 1 = M, 2 = W); remaining latency is tnew minus age.
  typedef struct {
    logic [4:0] dst, rs, rt;
    int         tnew;
    bit         movz;
    int         age;
  } ins_t;

  ins_t q[$];

  function automatic int rem(input ins_t x);
    return (x.tnew > x.age) ? x.tnew - x.age : 0;
  endfunction

  function automatic bit m_haz(input logic [4:0] r, input int tuse);
    if (tuse == 3 || r == 0) return 0;
    foreach (q[i]) if (q[i].age <= 1 && q[i].dst == r && rem(q[i]) > tuse) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r, input int min_age);
    if (r == 0) return 2'd0;
    for (int a = 1; a <= 2; a++)
      foreach (q[i])
        if (a >= min_age && q[i].age == a && q[i].dst == r && rem(q[i]) == 0) return a[1:0];
    return 2'd0;
  endfunction

  task automatic test_random();
    ins_t cur, nxt;
    bit   hold, rst, es;
    logic [1:0] ef_rs_d, ef_rt_d, ef_rs_e, ef_rt_e;
    logic ef_m, esel;
    do_reset();
    q.delete();
    hold = 0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        cur.rs = 5'($urandom_range(0, 6)); cur.rt = 5'($urandom_range(0, 6));
        cur.dst = 5'($urandom_range(0, 6)); cur.tnew = $urandom_range(0, 2);
        cur.movz = ($urandom_range(0, 4) == 0); cur.age = 0;
        d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
      end
      d_rs = cur.rs; d_rt = cur.rt; d_dst = cur.dst; d_tnew = 2'(cur.tnew); d_movz = cur.movz;
      e_rs = '0; e_rt = '0; m_rt = '0; esel = 1'b1;
      e_rt_zero = $urandom_range(0, 1);
      foreach (q[i]) begin
        if (q[i].age == 0) begin e_rs = q[i].rs; e_rt = q[i].rt; if (q[i].movz) esel = e_rt_zero; end
        if (q[i].age == 1) m_rt = q[i].rt;
      end
      rst = ($urandom_range(0, 59) == 0);
      reset = rst;
      #1;
      if (rst) begin
        es = 0; esel = 1'b1; ef_rs_d = 0; ef_rt_d = 0; ef_rs_e = 0; ef_rt_e = 0; ef_m = 0;
      end else begin
        es = m_haz(d_rs, d_tuse_rs) || m_haz(d_rt, d_tuse_rt);
        ef_rs_d = m_fwd(d_rs, 1); ef_rt_d = m_fwd(d_rt, 1);
        ef_rs_e = m_fwd(e_rs, 1); ef_rt_e = m_fwd(e_rt, 1);
        ef_m = (m_fwd(m_rt, 2) == 2'd2);
      end
      n_cmp++; if (stall !== es) begin n_bad++; $display("FAIL rnd_stall c=%0d got %0d want %0d", c, stall, es); end
      n_cmp++; if (e_dst_sel !== esel) begin n_bad++; $display("FAIL rnd_sel c=%0d got %0d want %0d", c, e_dst_sel, esel); end
      n_cmp++; if (fwd_rs_d !== ef_rs_d) begin n_bad++; $display("FAIL rnd_fwd_rs_d c=%0d got %0d want %0d", c, fwd_rs_d, ef_rs_d); end
      n_cmp++; if (fwd_rt_d !== ef_rt_d) begin n_bad++; $display("FAIL rnd_fwd_rt_d c=%0d got %0d want %0d", c, fwd_rt_d, ef_rt_d); end
      n_cmp++; if (fwd_rs_e !== ef_rs_e) begin n_bad++; $display("FAIL rnd_fwd_rs_e c=%0d got %0d want %0d", c, fwd_rs_e, ef_rs_e); end
      n_cmp++; if (fwd_rt_e !== ef_rt_e) begin n_bad++; $display("FAIL rnd_fwd_rt_e c=%0d got %0d want %0d", c, fwd_rt_e, ef_rt_e); end
      n_cmp++; if (fwd_rt_m !== ef_m) begin n_bad++; $display("FAIL rnd_fwd_rt_m c=%0d got %0d want %0d", c, fwd_rt_m, ef_m); end
      if (rst) begin
        q.delete();
        hold = 0;
      end else begin
        foreach (q[i]) begin
          if (q[i].age == 0 && q[i].movz && !e_rt_zero) q[i].dst = 0;
          q[i].movz = 0;
          q[i].age++;
        end
        q = q.find(x) with (x.age <= 2);
        nxt = cur;
        if (es) begin nxt.dst = 0; nxt.rs = 0; nxt.rt = 0; nxt.tnew = 0; nxt.movz = 0; end
        nxt.age = 0;
        q.push_back(nxt);
        hold = es;
      end
      cyc();
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch_alu();
    test_movz(1'b0);
    test_movz(1'b1);
    test_double_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
